// File: rtl/fifo_ctrl.sv
// Pointer, occupancy and flag controller for an external FIFO storage array.
// Grants client requests against full/empty and registers returned read data.
module fifo_ctrl #(
   parameter int unsigned MEM_SIZE  = 8,
   parameter int unsigned WORD_SIZE = 10,
   parameter int unsigned PTR_L     = 3,
   parameter int unsigned AF_TH     = 6,
   parameter int unsigned AE_TH     = 2
) (
   input  logic                 clk,
   input  logic                 reset_L,
   input  logic                 push_req,
   input  logic                 pop_req,
   input  logic [WORD_SIZE-1:0] data_in,
   input  logic [WORD_SIZE-1:0] data_out_MM,
   output logic                 push,
   output logic                 pop,
   output logic [PTR_L-1:0]     wr_ptr,
   output logic [PTR_L-1:0]     rd_ptr,
   output logic [WORD_SIZE-1:0] data_in_MM,
   output logic [WORD_SIZE-1:0] data_out,
   output logic                 data_valid,
   output logic [PTR_L:0]       fifo_count,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic                 overflow_err,
   output logic                 underflow_err
);

   localparam int unsigned CNT_W = PTR_L + 1;
   localparam logic [PTR_L-1:0] LAST_PTR = PTR_L'(MEM_SIZE - 1);

   // Status flags decode the registered occupancy only.
   always_comb begin
      full         = (fifo_count == CNT_W'(MEM_SIZE));
      empty        = (fifo_count == '0);
      almost_full  = (fifo_count >= CNT_W'(AF_TH));
      almost_empty = (fifo_count <= CNT_W'(AE_TH));
   end

   // Strobes are gated by reset so the array sees nothing while reset is held.
   always_comb begin
      push       = reset_L & push_req & ~full;
      pop        = reset_L & pop_req & ~empty;
      data_in_MM = data_in;
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr <= '0;
      end else if (push) begin
         wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_L'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rd_ptr <= '0;
      end else if (pop) begin
         rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_L'(1);
      end
   end

   // Simultaneous push and pop leave occupancy unchanged.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         fifo_count <= '0;
      end else if (push && !pop) begin
         fifo_count <= fifo_count + CNT_W'(1);
      end else if (pop && !push) begin
         fifo_count <= fifo_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= pop;
         if (pop) data_out <= data_out_MM;
      end
   end

   // Sticky request-versus-flag errors; only reset clears them.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         if (push_req && full)  overflow_err  <= 1'b1;
         if (pop_req && empty)  underflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized scoreboard bench for fifo_ctrl with a queue-based FIFO reference
// model and a simple storage-array model attached to the access ports.
module tb_fifo_ctrl;

   localparam int unsigned MEM_SIZE  = 8;
   localparam int unsigned WORD_SIZE = 10;
   localparam int unsigned PTR_L     = 3;
   localparam int unsigned AF_TH     = 6;
   localparam int unsigned AE_TH     = 2;

   logic                 clk = 1'b0;
   logic                 reset_L = 1'b0;
   logic                 push_req = 1'b0;
   logic                 pop_req = 1'b0;
   logic [WORD_SIZE-1:0] data_in = '0;
   logic [WORD_SIZE-1:0] data_out_MM;
   logic                 push, pop;
   logic [PTR_L-1:0]     wr_ptr, rd_ptr;
   logic [WORD_SIZE-1:0] data_in_MM, data_out;
   logic                 data_valid;
   logic [PTR_L:0]       fifo_count;
   logic                 full, empty, almost_full, almost_empty;
   logic                 overflow_err, underflow_err;

   fifo_ctrl #(
      .MEM_SIZE(MEM_SIZE), .WORD_SIZE(WORD_SIZE), .PTR_L(PTR_L),
      .AF_TH(AF_TH), .AE_TH(AE_TH)
   ) dut (
      .clk(clk), .reset_L(reset_L), .push_req(push_req), .pop_req(pop_req),
      .data_in(data_in), .data_out_MM(data_out_MM), .push(push), .pop(pop),
      .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .data_in_MM(data_in_MM),
      .data_out(data_out), .data_valid(data_valid), .fifo_count(fifo_count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow_err(overflow_err),
      .underflow_err(underflow_err)
   );

   always #5 clk = ~clk;

   // Storage array attached to the controller's access side.
   logic [WORD_SIZE-1:0] mem [MEM_SIZE];
   always @(posedge clk) if (push) mem[wr_ptr] <= data_in_MM;
   assign data_out_MM = mem[rd_ptr];

   // Reference model state.
   logic [WORD_SIZE-1:0] mq[$];
   logic [WORD_SIZE-1:0] sb[$];
   int m_wr = 0, m_rd = 0;
   bit m_ovf = 0, m_udf = 0;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      sb.delete();
      m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0;
   endtask

   // Monitor: every data_valid pulse must match the oldest expected pop.
   initial begin
      logic [WORD_SIZE-1:0] e;
      forever begin
         @(negedge clk);
         if (data_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_data_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("data_out", int'(data_out), int'(e));
            end
         end
      end
   end

   // One clock of stimulus: check outputs against the model, then advance it.
   task automatic cycle(input bit pr, input bit po, input logic [WORD_SIZE-1:0] d);
      int  n;
      bit  gp, gq;
      @(negedge clk);
      push_req = pr; pop_req = po; data_in = d;
      #1;
      n  = mq.size();
      gp = pr && (n != MEM_SIZE);
      gq = po && (n != 0);
      chk("push", int'(push), int'(gp));
      chk("pop", int'(pop), int'(gq));
      chk("fifo_count", int'(fifo_count), n);
      chk("full", int'(full), int'(n == MEM_SIZE));
      chk("empty", int'(empty), int'(n == 0));
      chk("almost_full", int'(almost_full), int'(n >= AF_TH));
      chk("almost_empty", int'(almost_empty), int'(n <= AE_TH));
      chk("wr_ptr", int'(wr_ptr), m_wr);
      chk("rd_ptr", int'(rd_ptr), m_rd);
      chk("overflow_err", int'(overflow_err), int'(m_ovf));
      chk("underflow_err", int'(underflow_err), int'(m_udf));
      chk("data_in_MM", int'(data_in_MM), int'(d));
      if (pr && n == MEM_SIZE) m_ovf = 1;
      if (po && n == 0) m_udf = 1;
      if (gq) begin
         sb.push_back(mq.pop_front());
         m_rd = (m_rd + 1) % MEM_SIZE;
      end
      if (gp) begin
         mq.push_back(d);
         m_wr = (m_wr + 1) % MEM_SIZE;
      end
   endtask

   // Asynchronous reset mid-cycle with requests held high.
   task automatic do_reset();
      @(negedge clk);
      #2;
      push_req = 1'b1; pop_req = 1'b1;
      reset_L = 1'b0;
      #1;
      model_reset();
      chk("rst_fifo_count", int'(fifo_count), 0);
      chk("rst_wr_ptr", int'(wr_ptr), 0);
      chk("rst_rd_ptr", int'(rd_ptr), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_almost_empty", int'(almost_empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_almost_full", int'(almost_full), 0);
      chk("rst_overflow_err", int'(overflow_err), 0);
      chk("rst_underflow_err", int'(underflow_err), 0);
      chk("rst_data_valid", int'(data_valid), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_push", int'(push), 0);
      chk("rst_pop", int'(pop), 0);
      @(posedge clk);
      #1;
      chk("rst_hold_count", int'(fifo_count), 0);
      chk("rst_hold_push", int'(push), 0);
      @(negedge clk);
      push_req = 1'b0; pop_req = 1'b0;
      reset_L = 1'b1;
   endtask

   task automatic random_phase(input int cycles, input int push_pct, input int pop_pct);
      for (int i = 0; i < cycles; i++) begin
         cycle(($urandom_range(0, 99) < push_pct), ($urandom_range(0, 99) < pop_pct),
               WORD_SIZE'($urandom));
      end
   endtask

   initial begin
      logic [WORD_SIZE-1:0] pat;
      do_reset();

      // Fill, then refused push at full, then push+pop at full.
      for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, WORD_SIZE'(i));
      cycle(1'b1, 1'b0, WORD_SIZE'(10'h3FF));
      cycle(1'b1, 1'b1, WORD_SIZE'(10'h2AA));
      cycle(1'b1, 1'b0, WORD_SIZE'(10'h009));
      for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, '0);

      // Both requests at empty, then read the word back.
      cycle(1'b1, 1'b1, WORD_SIZE'(10'h155));
      cycle(1'b0, 1'b1, '0);
      cycle(1'b0, 1'b0, '0);

      // Preload three words then sustained simultaneous traffic.
      pat = WORD_SIZE'(10'h040);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, pat);
         pat = pat + WORD_SIZE'(1);
      end
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, 1'b1, pat);
         pat = pat + WORD_SIZE'(1);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, '0);

      random_phase(150, 70, 30);
      random_phase(150, 30, 70);
      random_phase(200, 50, 50);

      // Bring occupancy to 5 and reset mid-stream.
      while (mq.size() > 5) cycle(1'b0, 1'b1, '0);
      while (mq.size() < 5) cycle(1'b1, 1'b0, WORD_SIZE'($urandom));
      do_reset();
      random_phase(200, 55, 45);

      cycle(1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, '0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
